// File: rtl/brc_pkg.sv
// Shared types and decode helpers for the chunked branch comparator.
package brc_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_e;

   function automatic logic brc_illegal(input logic [2:0] f);
      return (f[2:1] == 2'b01);
   endfunction

   function automatic logic brc_taken(input logic [2:0] f, input logic lt, input logic eq);
      logic t;
      case (funct3_e'(f))
         BEQ:       t = eq;
         BNE:       t = !eq;
         BLT, BLTU: t = lt;
         BGE, BGEU: t = !lt;
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// Combinational CHUNK-wide magnitude/equality compare with optional MSB flip
// so the top chunk of a signed operand orders correctly as unsigned.
module brc_chunk_cmp #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             inv_msb_i,
   output logic             lt_o,
   output logic             eq_o
);

   logic [CHUNK-1:0] flip;
   logic [CHUNK-1:0] a_x;
   logic [CHUNK-1:0] b_x;

   always_comb begin
      flip            = '0;
      flip[CHUNK-1]   = inv_msb_i;
      a_x             = a_i ^ flip;
      b_x             = b_i ^ flip;
      lt_o            = (a_x < b_x);
      eq_o            = (a_i == b_i);
   end

endmodule

// File: rtl/brc_seq.sv
// Multi-cycle RISC-V branch comparator: walks operands MSB chunk first and
// stops at the first differing chunk.
module brc_seq
   import brc_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [2:0]      funct3,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            br_less,
   output logic            br_equal,
   output logic            br_taken,
   output logic            br_illegal
);

   localparam int unsigned NCHUNK = XLEN / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

   if ((XLEN % CHUNK) != 0 || CHUNK < 2) begin : g_param_chk
      $error("brc_seq: XLEN must be a multiple of CHUNK and CHUNK >= 2");
   end

   state_e            state_q, state_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [2:0]        f3_q, f3_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              less_q, less_d;
   logic              equal_q, equal_d;
   logic              taken_q, taken_d;
   logic              illegal_q, illegal_d;

   logic [CHUNK-1:0]  a_chunk;
   logic [CHUNK-1:0]  b_chunk;
   logic              inv_msb;
   logic              chunk_lt;
   logic              chunk_eq;

   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int unsigned i = 0; i < NCHUNK; i++) begin
         if (idx_q == IDXW'(i)) begin
            a_chunk = rs1_q[i*CHUNK +: CHUNK];
            b_chunk = rs2_q[i*CHUNK +: CHUNK];
         end
      end
      inv_msb = (idx_q == IDX_TOP) && !f3_q[1];
   end

   brc_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
      .a_i       (a_chunk),
      .b_i       (b_chunk),
      .inv_msb_i (inv_msb),
      .lt_o      (chunk_lt),
      .eq_o      (chunk_eq)
   );

   always_comb begin
      state_d   = state_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      f3_d      = f3_q;
      idx_d     = idx_q;
      less_d    = less_q;
      equal_d   = equal_q;
      taken_d   = taken_q;
      illegal_d = illegal_q;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  rs1_d   = rs1_data;
                  rs2_d   = rs2_data;
                  f3_d    = funct3;
                  idx_d   = IDX_TOP;
                  state_d = CMP;
               end
            end
            CMP: begin
               if (!chunk_eq || idx_q == '0) begin
                  less_d    = chunk_eq ? 1'b0 : chunk_lt;
                  equal_d   = chunk_eq;
                  illegal_d = brc_illegal(f3_q);
                  taken_d   = !illegal_d && brc_taken(f3_q, less_d, equal_d);
                  state_d   = DONE;
               end else begin
                  idx_d = idx_q - IDXW'(1);
               end
            end
            DONE: begin
               if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rs1_q     <= '0;
         rs2_q     <= '0;
         f3_q      <= '0;
         idx_q     <= '0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         f3_q      <= f3_d;
         idx_q     <= idx_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
         taken_q   <= taken_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign br_less    = less_q;
   assign br_equal   = equal_q;
   assign br_taken   = taken_q;
   assign br_illegal = illegal_q;

endmodule

// File: tb/tb_brc_seq.sv
// Scoreboard bench for brc_seq (XLEN=32, CHUNK=8): expected results queued at
// request time, popped and compared when out_valid appears.
module tb_brc_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [2:0]  funct3;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        br_less;
   logic        br_equal;
   logic        br_taken;
   logic        br_illegal;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic less;
      logic equal;
      logic taken;
      logic illegal;
      int   lat;
   } exp_t;

   exp_t sb_q[$];

   brc_seq #(.XLEN(32), .CHUNK(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .funct3     (funct3),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .br_less    (br_less),
      .br_equal   (br_equal),
      .br_taken   (br_taken),
      .br_illegal (br_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      exp_t e;
      e.equal   = (a == b);
      e.less    = f[1] ? (a < b) : ($signed(a) < $signed(b));
      e.illegal = (f == 3'b010) || (f == 3'b011);
      case (f)
         3'b000:         e.taken = e.equal;
         3'b001:         e.taken = !e.equal;
         3'b100, 3'b110: e.taken = e.less;
         3'b101, 3'b111: e.taken = !e.less;
         default:        e.taken = 1'b0;
      endcase
      e.lat = 4;
      for (int i = 3; i >= 0; i--) begin
         if (a[i*8 +: 8] != b[i*8 +: 8]) begin
            e.lat = 4 - i;
            break;
         end
      end
      return e;
   endfunction

   task automatic chk_result(input string tag, input exp_t e);
      chk({tag, ".less"},    br_less,    e.less);
      chk({tag, ".equal"},   br_equal,   e.equal);
      chk({tag, ".taken"},   br_taken,   e.taken);
      chk({tag, ".illegal"}, br_illegal, e.illegal);
   endtask

   // Called just after a negedge; returns just after a negedge with DUT in IDLE.
   task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input int hold);
      exp_t e;
      int   cyc;
      sb_q.push_back(model(a, b, f));
      chk({tag, ".in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      rs1_data = a;
      rs2_data = b;
      funct3   = f;
      @(negedge clk);
      in_valid = 1'b0;
      rs1_data = $urandom;
      rs2_data = $urandom;
      funct3   = 3'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      e = sb_q.pop_front();
      if (!out_valid) begin
         chk({tag, ".timeout"}, 1'b1, 1'b0);
         return;
      end
      chk({tag, ".latency"}, cyc, e.lat);
      chk_result(tag, e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, ".hold_valid"}, out_valid, 1'b1);
         chk({tag, ".hold_ready"}, in_ready, 1'b0);
         chk_result({tag, ".hold"}, e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".ret_valid"}, out_valid, 1'b0);
      chk({tag, ".ret_idle"},  in_ready,  1'b1);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      bit          seen;

      rst       = 1'b1;
      in_valid  = 1'b0;
      rs1_data  = '0;
      rs2_data  = '0;
      funct3    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst.in_ready",  in_ready,   1'b1);
      chk("rst.out_valid", out_valid,  1'b0);
      chk("rst.less",      br_less,    1'b0);
      chk("rst.equal",     br_equal,   1'b0);
      chk("rst.taken",     br_taken,   1'b0);
      chk("rst.illegal",   br_illegal, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_req("beq_eq",   32'h10,       32'h10,       3'b000, 0);
      do_req("blt",      32'h10,       32'hFFFFFFE0, 3'b100, 0);
      do_req("bltu",     32'h10,       32'hFFFFFFE0, 3'b110, 0);
      do_req("bne",      32'hFFFFFFFF, 32'hFFFFFFFE, 3'b001, 0);
      do_req("ill010",   32'hFFFFFFFF, 32'hFFFFFFFE, 3'b010, 0);
      do_req("ill011",   32'h12345678, 32'h12345678, 3'b011, 0);
      do_req("bge_neg",  32'h80000000, 32'h7FFFFFFF, 3'b101, 0);
      do_req("bgeu_mid", 32'h00FF0000, 32'h00FE0000, 3'b111, 0);
      do_req("beq_hold", 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 3);

      // Flush during the second CMP cycle.
      in_valid = 1'b1;
      rs1_data = 32'h55;
      rs2_data = 32'h55;
      funct3   = 3'b000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush.idle",  in_ready,  1'b1);
      chk("flush.valid", out_valid, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("flush.no_result", seen, 1'b0);
      do_req("post_flush", 32'h00000001, 32'h00000002, 3'b100, 0);

      // Flush wins over a simultaneous request in IDLE.
      flush    = 1'b1;
      in_valid = 1'b1;
      rs1_data = 32'h1;
      rs2_data = 32'h2;
      funct3   = 3'b100;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_in.idle", in_ready, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen = 1'b1;
      end
      chk("flush_in.no_accept", seen, 1'b0);

      // Asynchronous reset in the middle of CMP.
      in_valid = 1'b1;
      rs1_data = 32'hA5A5A5A5;
      rs2_data = 32'hA5A5A5A4;
      funct3   = 3'b001;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst.in_ready",  in_ready,   1'b1);
      chk("midrst.out_valid", out_valid,  1'b0);
      chk("midrst.less",      br_less,    1'b0);
      chk("midrst.equal",     br_equal,   1'b0);
      chk("midrst.taken",     br_taken,   1'b0);
      chk("midrst.illegal",   br_illegal, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst.no_result", seen, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = a;
            2:       b = {a[31:8], 8'($urandom)};
            default: b = {a[31:16], 16'($urandom)};
         endcase
         do_req("rand", a, b, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end

      chk("sb.empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/brc_seq.md
BRC_SEQ -- requirements
Module: brc_seq

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits compared per cycle; XLEN % CHUNK == 0 and CHUNK >= 2, enforced by elaboration-time assertion.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  request valid.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 rs1_data  in  XLEN  first operand.
REQ-008 rs2_data  in  XLEN  second operand.
REQ-009 funct3  in  3  RISC-V branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 flush  in  1  synchronous abort of any in-flight compare.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 br_less  out  1  rs1 < rs2 under the selected signedness.
REQ-014 br_equal  out  1  rs1 == rs2.
REQ-015 br_taken  out  1  branch decision for funct3.
REQ-016 br_illegal  out  1  funct3 is 010 or 011.

Function
REQ-017 States SHALL be IDLE, CMP and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE: on in_valid && in_ready, rs1_data, rs2_data and funct3 SHALL be latched, chunk index SHALL be set to XLEN/CHUNK-1 (MSB chunk), and the state SHALL move to CMP.
REQ-019 Signedness: br_un = funct3[1]; when br_un = 0, the MSB of both operands SHALL be inverted before unsigned compare of the top chunk.
REQ-020 CMP, per cycle: compare the indexed chunk; if the chunks differ, then br_less = (rs1 chunk < rs2 chunk), br_equal = 0, next state DONE.
REQ-021 CMP: if the chunks are equal and index == 0, then br_equal = 1, br_less = 0, next state DONE; otherwise, decrement the index and stay in CMP.
REQ-022 Latency: out_valid SHALL rise k cycles after the accept edge, where k = 1 + (number of equal chunks above the first differing chunk), k <= XLEN/CHUNK.
REQ-023 br_taken: BEQ = equal, BNE = !equal, BLT/BLTU = less, BGE/BGEU = !less.
REQ-024 Illegal funct3: br_taken = 0 and br_illegal = 1, with the same latency as a valid compare.
REQ-025 DONE: all result outputs SHALL stay stable while out_valid && !out_ready.
REQ-026 DONE: on out_ready, the state SHALL return to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-027 flush = 1 in any state SHALL force IDLE at the next edge and drop out_valid.
REQ-028 flush together with in_valid in IDLE: flush wins, and no request is accepted.
REQ-029 Result outputs SHALL be don't-care when out_valid = 0, but SHALL be registered.

Reset
REQ-030 rst SHALL asynchronously force IDLE, with in_ready = 1, out_valid = 0, and br_less, br_equal, br_taken, br_illegal and the chunk index all 0.
REQ-031 rst asserted mid-CMP or mid-DONE SHALL discard the request; no result SHALL appear after release.

Structure
REQ-032 Package brc_pkg SHALL hold the funct3 enum (BEQ..BGEU) and the state enum (IDLE/CMP/DONE).
REQ-033 Sub-module brc_chunk_cmp SHALL be the combinational CHUNK-wide comparator with a sign-invert input, producing lt and eq.
REQ-034 The chunk index width SHALL be $clog2(XLEN/CHUNK), with a minimum of 1.

Verification (XLEN = 32, CHUNK = 8)
REQ-035 rs1 = 0x10, rs2 = 0x10, BEQ -> out_valid 4 cycles after accept; equal = 1, less = 0, taken = 1.
REQ-036 rs1 = 0x10, rs2 = 0xFFFFFFE0, BLT -> latency 1, less = 0, taken = 0; same operands with BLTU -> latency 1, less = 1, taken = 1.
REQ-037 rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFE, BNE -> latency 4, equal = 0, less = 0, taken = 1; funct3 = 010 -> illegal = 1, taken = 0.
REQ-038 BEQ on equal operands with out_ready held 0 for 3 cycles -> outputs stable and in_ready = 0 throughout; return to IDLE one cycle after out_ready = 1.
REQ-039 flush in the second CMP cycle -> IDLE next cycle, no out_valid; a following request compares correctly.
REQ-040 rst pulse mid-CMP -> immediate IDLE with reset values; back-to-back requests then match a reference model over 1000 random operands across all funct3 values.
